// File: rtl/spi_burst_controller.sv
// SPI burst master: 1..NUM_WORDS words per frame, all CPOL/CPHA modes, MSB/LSB first.
// Define SPI_BURST_SS_GAP_EN to frame each word separately with an SS_GAP-cycle SS_n gap.
module spi_burst_controller #(
  parameter int DATA_BITS = 8,
  parameter int NUM_WORDS = 4,
  parameter int CLK_DIV   = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter int SS_GAP    = 2,
  localparam int CNT_W = $clog2(NUM_WORDS + 1),
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_W-1:0]               word_count,
  input  logic [NUM_WORDS*DATA_BITS-1:0] tx_words,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_WORDS*DATA_BITS-1:0] rx_words,
  output logic                           rx_strobe,
  output logic [IDX_W-1:0]               rx_index,
  output logic                           SCK,
  output logic                           SS_n,
  output logic                           MOSI,
  input  logic                           MISO
);

  localparam int WB    = NUM_WORDS * DATA_BITS;
  localparam int TW    = $clog2(2 * DATA_BITS);
  localparam int DIV_W = $clog2(CLK_DIV + SS_GAP + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_WORDS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TW-1:0]    TOG_LAST = TW'(2 * DATA_BITS - 1);
`ifdef SPI_BURST_SS_GAP_EN
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((SS_GAP > 1) ? SS_GAP - 1 : 0);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t               state_r;
  logic [WB-1:0]        tx_buf_r;
  logic [WB-1:0]        rx_words_r;
  logic [DATA_BITS-1:0] rx_sr_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     word_idx_r;
  logic [TW-1:0]        tog_cnt_r;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [IDX_W-1:0]     rx_index_r;
  logic                 busy_r, done_r, rx_strobe_r, sck_r, ss_n_r, mosi_r;

  logic [CNT_W-1:0]     clamped_s;
  logic [CNT_W-1:0]     next_word_s;
  logic [DATA_BITS-1:0] rx_shift_s;
  logic                 div_end_s, word_end_s, odd_toggle_s, more_s;

  // Bit b_idx (in transmit order) of word w_idx.
  function automatic logic word_bit(input logic [WB-1:0] words, input int w_idx, input int b_idx);
    int pos;
    pos = LSB_FIRST ? b_idx : (DATA_BITS - 1 - b_idx);
    if (w_idx < NUM_WORDS) begin
      word_bit = words[w_idx * DATA_BITS + pos];
    end else begin
      word_bit = 1'b0;
    end
  endfunction

  // Word count clamp, receive shift candidate and sequencing flags.
  always_comb begin
    if (word_count > MAX_CNT) begin
      clamped_s = MAX_CNT;
    end else begin
      clamped_s = word_count;
    end
    if (LSB_FIRST) begin
      rx_shift_s = {MISO, rx_sr_r[DATA_BITS-1:1]};
    end else begin
      rx_shift_s = {rx_sr_r[DATA_BITS-2:0], MISO};
    end
    next_word_s  = word_idx_r + CNT_W'(1);
    more_s       = (next_word_s < count_r);
    div_end_s    = (div_cnt_r == DIV_LAST);
    word_end_s   = (tog_cnt_r == TOG_LAST);
    odd_toggle_s = (tog_cnt_r[0] == 1'b0);
  end

  // Burst sequencer: SCK/MOSI generation, MISO capture and registered status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      tx_buf_r    <= '0;
      rx_words_r  <= '0;
      rx_sr_r     <= '0;
      count_r     <= '0;
      word_idx_r  <= '0;
      tog_cnt_r   <= '0;
      div_cnt_r   <= '0;
      rx_index_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rx_strobe_r <= 1'b0;
      sck_r       <= CPOL;
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      rx_strobe_r <= 1'b0;
      case (state_r)
        IDLE: begin
          div_cnt_r  <= '0;
          tog_cnt_r  <= '0;
          word_idx_r <= '0;
          if (start) begin
            tx_buf_r <= tx_words;
            count_r  <= clamped_s;
            if (clamped_s == '0) begin
              state_r <= FINISH;
              done_r  <= 1'b1;
            end else begin
              state_r <= SETUP;
              busy_r  <= 1'b1;
              ss_n_r  <= 1'b0;
              sck_r   <= CPOL;
              mosi_r  <= word_bit(tx_words, 0, 0);
            end
          end
        end
        SETUP: begin
          ss_n_r <= 1'b0;
          if (div_end_s) begin
            div_cnt_r <= '0;
            state_r   <= SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (div_end_s) begin
            div_cnt_r <= '0;
            sck_r     <= ~sck_r;
            if (odd_toggle_s != CPHA) begin
              rx_sr_r <= rx_shift_s;
            end
            if (word_end_s) begin
              // CPHA=1 samples the last bit on this very toggle.
              tog_cnt_r   <= '0;
              rx_words_r[int'(word_idx_r) * DATA_BITS +: DATA_BITS] <= CPHA ? rx_shift_s : rx_sr_r;
              rx_strobe_r <= 1'b1;
              rx_index_r  <= IDX_W'(word_idx_r);
              word_idx_r  <= next_word_s;
              if (more_s) begin
                mosi_r <= word_bit(tx_buf_r, int'(next_word_s), 0);
`ifdef SPI_BURST_SS_GAP_EN
                state_r <= HOLD;
`endif
              end else begin
                state_r <= HOLD;
              end
            end else begin
              tog_cnt_r <= tog_cnt_r + TW'(1);
              if (odd_toggle_s == CPHA) begin
                mosi_r <= word_bit(tx_buf_r, int'(word_idx_r), (int'(tog_cnt_r) + 1) / 2);
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_end_s) begin
            div_cnt_r <= '0;
`ifdef SPI_BURST_SS_GAP_EN
            if (word_idx_r != count_r) begin
              state_r <= GAP;
              ss_n_r  <= 1'b1;
            end else begin
              state_r <= FINISH;
              ss_n_r  <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end
`else
            state_r <= FINISH;
            ss_n_r  <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
`endif
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
`ifdef SPI_BURST_SS_GAP_EN
        GAP: begin
          if (div_cnt_r == GAP_LAST) begin
            div_cnt_r <= '0;
            state_r   <= SETUP;
            ss_n_r    <= 1'b0;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
`endif
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign rx_words  = rx_words_r;
  assign rx_strobe = rx_strobe_r;
  assign rx_index  = rx_index_r;
  assign SCK       = sck_r;
  assign SS_n      = ss_n_r;
  assign MOSI      = mosi_r;

endmodule

// File: tb/tb_spi_burst_controller.sv
// Bench for spi_burst_controller: mode 0 loopback instance plus a mode 3 LSB-first instance
// with a slave model; received words go through an expected-value queue.
module tb_spi_burst_controller;

  localparam int CD = 2;
  localparam int DB = 8;
  localparam int BUDGET = 400;
`ifdef SPI_BURST_SS_GAP_EN
  localparam int SSG = 2;
  localparam int GAP_ADD = 2 * CD + SSG;
  localparam int LOW_ADD = 2 * CD;
`else
  localparam int SSG = 0;
  localparam int GAP_ADD = 0;
  localparam int LOW_ADD = 0;
`endif

  logic        clk, reset;
  logic        start0, start3;
  logic [2:0]  wc0, wc3;
  logic [31:0] tx0, tx3, rx0, rx3;
  logic        busy0, done0, strb0, sck0, ssn0, mosi0;
  logic        busy3, done3, strb3, sck3, ssn3, mosi3, miso3;
  logic [1:0]  idx0, idx3;

  spi_burst_controller u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .word_count(wc0), .tx_words(tx0),
    .busy(busy0), .done(done0), .rx_words(rx0), .rx_strobe(strb0), .rx_index(idx0),
    .SCK(sck0), .SS_n(ssn0), .MOSI(mosi0), .MISO(mosi0)
  );

  spi_burst_controller #(.CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .word_count(wc3), .tx_words(tx3),
    .busy(busy3), .done(done3), .rx_words(rx3), .rx_strobe(strb3), .rx_index(idx3),
    .SCK(sck3), .SS_n(ssn3), .MOSI(mosi3), .MISO(miso3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Slave for the mode 3 instance: shifts 0x81 then 0x7E out LSB first on SCK leading edges.
  logic [15:0] slave_stream = 16'h7E81;
  int sidx = 0;
  always @(negedge sck3 or posedge start3) begin
    if (start3) sidx <= 0;
    else if (!ssn3 && sidx < 16) begin
      miso3 <= slave_stream[sidx];
      sidx  <= sidx + 1;
    end
  end

  logic sel;
  logic o_busy, o_done, o_strb, o_sck, o_ssn, o_mosi;
  logic [31:0] o_rx;
  logic [1:0]  o_idx;
  always_comb begin
    if (sel) begin
      o_busy = busy3; o_done = done3; o_strb = strb3; o_sck = sck3;
      o_ssn = ssn3; o_mosi = mosi3; o_rx = rx3; o_idx = idx3;
    end else begin
      o_busy = busy0; o_done = done0; o_strb = strb0; o_sck = sck0;
      o_ssn = ssn0; o_mosi = mosi0; o_rx = rx0; o_idx = idx0;
    end
  end

  logic [7:0] exp_w[$];
  int         exp_i[$];
  int         exp_c[$];
  int done_at, ss_low, ss_high_busy, toggles, busy_cnt, mosi_n;
  logic [31:0] mosi_cap;

  function automatic int exp_done(input int n);
    return (n == 0) ? 1 : 1 + CD * (2 + 2 * DB * n) + (n - 1) * GAP_ADD;
  endfunction

  function automatic int exp_low(input int n);
    return (n == 0) ? 0 : CD * (2 + 2 * DB * n) + (n - 1) * LOW_ADD;
  endfunction

  function automatic logic [31:0] exp_mosi(input logic [31:0] tx, input int n, input bit lsb);
    logic [31:0] cap;
    cap = 32'h0;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < DB; b++)
        cap[w * DB + b] = tx[w * DB + (lsb ? b : DB - 1 - b)];
    return cap;
  endfunction

  task automatic push_exp(input logic [7:0] w, input int k);
    exp_w.push_back(w);
    exp_i.push_back(k);
    exp_c.push_back(1 + CD * (1 + 2 * DB * (k + 1)) + k * GAP_ADD);
  endtask

  // Drives one burst and records what the chosen instance does; strobes are scored as they appear.
  task automatic run_burst(input bit which, input logic [2:0] wc, input logic [31:0] tx);
    logic prev_sck, prev_mosi;
    logic [7:0] got, ew;
    int ei, ec;
    done_at = -1; ss_low = 0; ss_high_busy = 0; toggles = 0; busy_cnt = 0;
    mosi_cap = 32'h0; mosi_n = 0;
    sel = which;
    @(negedge clk);
    if (which) begin start3 = 1'b1; wc3 = wc; tx3 = tx; end
    else begin start0 = 1'b1; wc0 = wc; tx0 = tx; end
    #1;
    prev_sck = o_sck; prev_mosi = o_mosi;
    @(negedge clk);
    start0 = 1'b0; start3 = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (o_busy) busy_cnt++;
      if (!o_ssn) ss_low++;
      if (o_busy && o_ssn) ss_high_busy++;
      if (o_sck !== prev_sck) begin
        toggles++;
        if (o_sck === 1'b1 && mosi_n < 32) begin
          mosi_cap[mosi_n] = prev_mosi;
          mosi_n++;
        end
      end
      if (o_strb) begin
        n_vec++;
        if (exp_w.size() == 0) begin
          n_err++;
          $display("FAIL rx_strobe: unexpected strobe idx %0d at cycle %0d", o_idx, cyc);
        end else begin
          ew = exp_w.pop_front(); ei = exp_i.pop_front(); ec = exp_c.pop_front();
          got = o_rx[int'(o_idx) * 8 +: 8];
          if (got !== ew || int'(o_idx) != ei || cyc != ec) begin
            n_err++;
            $display("FAIL rx_word: got %02h idx %0d cycle %0d, expected %02h idx %0d cycle %0d",
                     got, o_idx, cyc, ew, ei, ec);
          end
        end
      end
      prev_sck = o_sck; prev_mosi = o_mosi;
      if (o_done) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (exp_w.size() != 0) begin
      n_err++;
      $display("FAIL rx_strobe_count: %0d expected strobes never seen", exp_w.size());
    end
    exp_w.delete(); exp_i.delete(); exp_c.delete();
  endtask

  task automatic check_timing(input string name, input int n);
    n_vec++;
    if (done_at != exp_done(n)) begin
      n_err++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done(n));
    end
    n_vec++;
    if (ss_low != exp_low(n)) begin
      n_err++; $display("FAIL %s ss_low: got %0d expected %0d", name, ss_low, exp_low(n));
    end
    n_vec++;
    if (toggles != 2 * DB * n) begin
      n_err++; $display("FAIL %s sck_toggles: got %0d expected %0d", name, toggles, 2 * DB * n);
    end
    n_vec++;
    if (busy_cnt != ((n == 0) ? 0 : exp_done(n) - 1)) begin
      n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt,
                        (n == 0) ? 0 : exp_done(n) - 1);
    end
    n_vec++;
    if (ss_high_busy != ((n == 0) ? 0 : (n - 1) * SSG)) begin
      n_err++; $display("FAIL %s ss_gap: got %0d expected %0d", name, ss_high_busy,
                        (n == 0) ? 0 : (n - 1) * SSG);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy0, done0, strb0, idx0, sck0, ssn0, mosi0} !== {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_ctl0: got %b", {busy0, done0, strb0, idx0, sck0, ssn0, mosi0});
    end
    n_vec++;
    if ({busy3, done3, strb3, idx3, sck3, ssn3, mosi3} !== {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_ctl3: got %b", {busy3, done3, strb3, idx3, sck3, ssn3, mosi3});
    end
    n_vec++;
    if (rx0 !== 32'h0 || rx3 !== 32'h0) begin
      n_err++; $display("FAIL reset_rx: got %h %h expected 0", rx0, rx3);
    end
    reset = 1'b0;
  endtask

  task automatic test_mode0_burst;
    for (int k = 0; k < 4; k++) push_exp(8'(32'h00FF3CA5 >> (8 * k)), k);
    run_burst(1'b0, 3'd4, 32'h00FF3CA5);
    check_timing("mode0", 4);
    n_vec++;
    if (rx0 !== 32'h00FF3CA5) begin n_err++; $display("FAIL mode0_rx: got %h expected 00ff3ca5", rx0); end
    n_vec++;
    if (mosi_cap !== exp_mosi(32'h00FF3CA5, 4, 1'b0)) begin
      n_err++; $display("FAIL mode0_mosi: got %h expected %h", mosi_cap, exp_mosi(32'h00FF3CA5, 4, 1'b0));
    end
    @(negedge clk);
    n_vec++;
    if (done0 !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b expected 0", done0); end
  endtask

  task automatic test_zero_count;
    run_burst(1'b0, 3'd0, 32'h11223344);
    check_timing("zero", 0);
    n_vec++;
    if (rx0 !== 32'h00FF3CA5) begin n_err++; $display("FAIL zero_rx: got %h expected 00ff3ca5", rx0); end
  endtask

  task automatic test_clamp;
    for (int k = 0; k < 4; k++) push_exp(8'(32'h12345678 >> (8 * k)), k);
    run_burst(1'b0, 3'd7, 32'h12345678);
    check_timing("clamp", 4);
    n_vec++;
    if (rx0 !== 32'h12345678) begin n_err++; $display("FAIL clamp_rx: got %h expected 12345678", rx0); end
  endtask

  task automatic test_mode3_lsb;
    push_exp(8'h81, 0);
    push_exp(8'h7E, 1);
    run_burst(1'b1, 3'd2, 32'hFFFF965A);
    check_timing("mode3", 2);
    n_vec++;
    if (rx3 !== 32'h00007E81) begin n_err++; $display("FAIL mode3_rx: got %h expected 00007e81", rx3); end
    n_vec++;
    if (mosi_cap !== 32'h0000965A) begin n_err++; $display("FAIL mode3_mosi: got %h expected 0000965a", mosi_cap); end
    n_vec++;
    if (sck3 !== 1'b1 || ssn3 !== 1'b1) begin n_err++; $display("FAIL mode3_idle: got sck %b ss_n %b expected 1 1", sck3, ssn3); end
  endtask

  task automatic test_back_to_back;
    push_exp(8'h5A, 0);
    run_burst(1'b0, 3'd1, 32'hAAAAAA5A);
    check_timing("b2b_first", 1);
    n_vec++;
    if (ssn0 !== 1'b1) begin n_err++; $display("FAIL b2b_ss_n: got %b expected 1", ssn0); end
    push_exp(8'hC3, 0);
    run_burst(1'b0, 3'd1, 32'h000000C3);
    check_timing("b2b_second", 1);
    n_vec++;
    if (rx0 !== 32'h123456C3) begin n_err++; $display("FAIL b2b_rx: got %h expected 123456c3", rx0); end
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    seen_done = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    start0 = 1'b1; wc0 = 3'd4; tx0 = 32'hDEADBEEF;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 2; c <= 49; c++) begin
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    n_vec++;
    if (ssn0 !== 1'b0 || busy0 !== 1'b1) begin n_err++; $display("FAIL mid_active: got ss_n %b busy %b expected 0 1", ssn0, busy0); end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({ssn0, sck0, busy0, mosi0, strb0} !== 5'b10000 || rx0 !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: got ss_n %b sck %b busy %b mosi %b strb %b rx %h",
                        ssn0, sck0, busy0, mosi0, strb0, rx0);
    end
    repeat (4) begin
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done) begin n_err++; $display("FAIL mid_no_done: got done pulse expected none"); end
    push_exp(8'h3C, 0);
    push_exp(8'hA5, 1);
    run_burst(1'b0, 3'd2, 32'h0000A53C);
    check_timing("after_reset", 2);
    n_vec++;
    if (rx0 !== 32'h0000A53C) begin n_err++; $display("FAIL after_reset_rx: got %h expected 0000a53c", rx0); end
  endtask

  initial begin
    start0 = 1'b0; start3 = 1'b0; wc0 = 3'd0; wc3 = 3'd0;
    tx0 = 32'h0; tx3 = 32'h0; sel = 1'b0; miso3 = 1'b0;
    test_reset();
    test_mode0_burst();
    test_zero_count();
    test_clamp();
    test_mode3_lsb();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_burst_controller.md
# spi_burst_controller

Parametrised SPI burst master that transmits and receives a run-time-selectable number of words (1 to NUM_WORDS) in one chip-select frame. It contains its own SCK generator and shift engine, supports all four CPOL/CPHA modes and MSB/LSB-first ordering, and uses a start/busy/done handshake. It sits between system logic that produces packed word vectors and an external SPI slave, and replaces the fixed four-word SPI controller.

## Interface
- DATA_BITS, 8, bits per word (>=2)
- NUM_WORDS, 4, maximum words per burst (>=1)
- CLK_DIV, 2, clk cycles per SCK half-period (>=1)
- CPOL, 0, SCK idle level
- CPHA, 0, 0: sample on leading edge; 1: shift on leading edge
- LSB_FIRST, 0, 1: bit 0 first on MOSI/MISO
- SS_GAP, 2, clk cycles SS_n held high between words (used only with SPI_BURST_SS_GAP_EN)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  request burst; sampled only when busy=0
- word_count  in  $clog2(NUM_WORDS+1)  words in burst; values > NUM_WORDS are clamped to NUM_WORDS
- tx_words  in  NUM_WORDS*DATA_BITS  word i at bits [i*DATA_BITS +: DATA_BITS]
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at end of burst
- rx_words  out  NUM_WORDS*DATA_BITS  received words, same packing as tx_words
- rx_strobe  out  1  one-cycle pulse when a received word is written
- rx_index  out  $clog2(NUM_WORDS) (min 1)  index of word written on rx_strobe
- SCK  out  1  serial clock
- SS_n  out  1  active-low slave select
- MOSI  out  1  serial data out
- MISO  in  1  serial data in

## Operation
- Reset values: busy=0, done=0, rx_words=0, rx_strobe=0, rx_index=0, SCK=CPOL, SS_n=1, MOSI=0.
- States: IDLE, SETUP, SHIFT, HOLD, GAP, FINISH.
- IDLE: on start=1, latch tx_words and the clamped word_count, and set word index to 0. Count 0 goes to FINISH. Count >=1 goes to SETUP.
- SETUP (CLK_DIV cycles): SS_n=0, SCK=CPOL, first bit on MOSI. Then go to SHIFT.
- SHIFT: SCK toggles every CLK_DIV cycles, with 2*DATA_BITS toggles per word.
  - CPHA=0: sample MISO on odd toggles; drive the next MOSI bit on even toggles.
  - CPHA=1: drive on odd toggles; sample on even toggles.
- After the final toggle of word k: the received word is written to rx_words slot k, with rx_strobe=1 and rx_index=k in the same cycle. If more words remain, the next word's first bit is driven and SHIFT continues with no idle half-period. Otherwise go to HOLD.
- HOLD (CLK_DIV cycles): SCK=CPOL, SS_n=0. Then go to FINISH.
- FINISH (1 cycle): SS_n=1, done=1. Go to IDLE. busy is 0 from that cycle on.
- busy=1 from the cycle after start is accepted through the cycle before FINISH.
- Inputs are ignored while busy=1, including start, tx_words and word_count.
- rx_words slots beyond word_count keep their prior values.
- Reset mid-burst returns all outputs to reset values immediately (SS_n=1, SCK=CPOL), with no done pulse.

## Timing
- start accepted at edge T. SETUP begins at T+1.
- done pulse at cycle T+1+CLK_DIV*(2+2*DATA_BITS*N) for N>=1 words (gap feature off).
- For N=0, done at T+1; SS_n never asserts.
- Word k's rx_strobe occurs at T+1+CLK_DIV*(1+2*DATA_BITS*(k+1)).
- start may be re-asserted in the cycle after done. Back-to-back bursts have SS_n high for at least 1 cycle.

## Configuration
- SPI_BURST_SS_GAP_EN defined: after each non-final word go SHIFT→HOLD→GAP→SETUP.
  - HOLD lasts CLK_DIV cycles with SS_n=0.
  - GAP lasts SS_GAP cycles with SS_n=1.
  - Each word becomes its own frame, and each non-final word adds 2*CLK_DIV+SS_GAP cycles.
- Not defined: GAP state is absent and SS_n stays low across the whole burst. SS_GAP is unused.

## Test plan
- Mode 0, DATA_BITS=8, NUM_WORDS=4, CLK_DIV=2, MISO tied to MOSI, tx=00,FF,3C,A5 (word3..0), count=4 → rx_words=00FF3CA5; 4 rx_strobes with index 0..3; done at T+133; SS_n low for 132 cycles.
- count=0 → done at T+1; SS_n stays 1; SCK never toggles; rx_words unchanged.
- count=7 (clamped to 4) → identical response to count=4.
- Mode 3, LSB_FIRST=1, slave model returning 0x81 then 0x7E, count=2 → rx word0=81, word1=7E; SCK idles high; MOSI bit order LSB-first verified against tx.
- reset asserted during word 1 bit 3 → SS_n=1 and SCK=CPOL within the same cycle; no done; a new start then completes normally.
- With SPI_BURST_SS_GAP_EN, SS_GAP=2, count=2, CLK_DIV=2 → SS_n high exactly 2 cycles between words; done at T+1+2*(2+32)+(2*2+2)=T+75.
